// File: rtl/gamesys_score_keeper.sv
// Score keeper: turns wall-pass strobes into a packed-BCD score weighted by
// difficulty, keeps the session high score and builds the display word that
// alternates score/high while the game is over.
module gamesys_score_keeper #(
  parameter int unsigned SHOW_CYCLES = 100_000_000,
  parameter int unsigned PEND_W      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pass_evt,
  input  logic        pause,
  input  logic        failed,
  input  logic [2:0]  diff,
  output logic [15:0] score_bcd,
  output logic [15:0] high_bcd,
  output logic [15:0] disp_bcd,
  output logic        new_high,
  output logic        busy
);

  localparam int unsigned      TW         = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TW-1:0]    TIMER_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [PEND_W:0]  PEND_MAX   = {1'b0, {PEND_W{1'b1}}};

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_OVER   = 2'd3
  } state_e;

  // BCD +1 with per-digit carry; 9999 is a hard ceiling.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) begin
      r = v;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          r[4*i +: 4] = v[4*i +: 4];
        end
      end
    end
    return r;
  endfunction

  state_e          state_q;
  logic [PEND_W-1:0] pend_q;
  logic [PEND_W-1:0] pend_d;
  logic [15:0]     score_q;
  logic [15:0]     high_q;
  logic [15:0]     disp_q;
  logic            new_high_q;
  logic            busy_q;
  logic [TW-1:0]   timer_q;
  logic            show_high_q;

  logic            accept_s;
  logic            dec_s;
  logic [PEND_W:0] add_s;
  logic [PEND_W:0] sum_s;
  logic [15:0]     score_inc_s;

  // Accept/drain decisions and the saturating pending-points update.
  always_comb begin
    accept_s    = (state_q == ST_RUN) && pass_evt && !pause && !failed;
    dec_s       = (pend_q != '0) && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    add_s       = '0;
    if (accept_s) begin
      add_s = (PEND_W+1)'(diff) + (PEND_W+1)'(1'b1);
    end else begin
      add_s = '0;
    end
    sum_s       = {1'b0, pend_q} - (PEND_W+1)'(dec_s) + add_s;
    pend_d      = sum_s[PEND_W-1:0];
    if (sum_s > PEND_MAX) begin
      pend_d = PEND_MAX[PEND_W-1:0];
    end else begin
      pend_d = sum_s[PEND_W-1:0];
    end
    score_inc_s = bcd_inc(score_q);
  end

  // Game-phase FSM with all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pend_q      <= '0;
      busy_q      <= 1'b0;
      score_q     <= 16'h0000;
      high_q      <= 16'h0000;
      disp_q      <= 16'h0000;
      new_high_q  <= 1'b0;
      timer_q     <= '0;
      show_high_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      busy_q <= (pend_d != '0);
      case (state_q)
        ST_RUN: begin
          disp_q <= score_q;
          if (dec_s) score_q <= score_inc_s;
          if (accept_s) new_high_q <= 1'b0;
          if (failed) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          disp_q <= score_q;
          if (dec_s) score_q <= score_inc_s;
          if (pend_q == '0) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          disp_q      <= score_q;
          timer_q     <= '0;
          show_high_q <= 1'b0;
          if (score_q > high_q) begin
            high_q     <= score_q;
            new_high_q <= 1'b1;
          end else begin
            new_high_q <= 1'b0;
          end
          state_q <= ST_OVER;
        end
        ST_OVER: begin
          disp_q <= show_high_q ? high_q : score_q;
          if (!failed) begin
            state_q     <= ST_RUN;
            score_q     <= 16'h0000;
            timer_q     <= '0;
            show_high_q <= 1'b0;
          end else if (timer_q == TIMER_LAST) begin
            timer_q     <= '0;
            show_high_q <= ~show_high_q;
          end else begin
            timer_q <= timer_q + TW'(1'b1);
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign score_bcd = score_q;
  assign high_bcd  = high_q;
  assign disp_bcd  = disp_q;
  assign new_high  = new_high_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gamesys_score_keeper.sv
// Directed bench for gamesys_score_keeper with a short show period.
module tb_gamesys_score_keeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        pass_evt;
  logic        pause;
  logic        failed;
  logic [2:0]  diff;
  logic [15:0] score_bcd;
  logic [15:0] high_bcd;
  logic [15:0] disp_bcd;
  logic        new_high;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_steps [8] = '{16'h0004, 16'h0005, 16'h0006, 16'h0007,
                                 16'h0008, 16'h0009, 16'h0010, 16'h0011};
  logic [15:0] exp_disp [12] = '{16'h0002, 16'h0002, 16'h0002, 16'h0002,
                                 16'h0005, 16'h0005, 16'h0005, 16'h0005,
                                 16'h0002, 16'h0002, 16'h0002, 16'h0002};

  gamesys_score_keeper #(.SHOW_CYCLES(4), .PEND_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .pass_evt  (pass_evt),
    .pause     (pause),
    .failed    (failed),
    .diff      (diff),
    .score_bcd (score_bcd),
    .high_bcd  (high_bcd),
    .disp_bcd  (disp_bcd),
    .new_high  (new_high),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse();
    pass_evt = 1'b1;
    step();
    pass_evt = 1'b0;
  endtask

  task automatic hold(input int n);
    pass_evt = 1'b1;
    repeat (n) step();
    pass_evt = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; pass_evt = 1'b0; pause = 1'b0; failed = 1'b0; diff = 3'd0;
    step(); step();
    chk_eq("rst_score", 32'(score_bcd), 32'h0);
    chk_eq("rst_high",  32'(high_bcd),  32'h0);
    chk_eq("rst_disp",  32'(disp_bcd),  32'h0);
    chk_eq("rst_nh",    32'(new_high),  32'h0);
    chk_eq("rst_busy",  32'(busy),      32'h0);
    reset = 1'b0;

    // 1: three single points, four cycles apart
    for (int i = 0; i < 3; i++) begin
      pulse();
      chk_eq("t1_busy_hi", 32'(busy), 32'h1);
      step();
      chk_eq("t1_busy_lo", 32'(busy), 32'h0);
      chk_eq("t1_score", 32'(score_bcd), 32'(i + 1));
      step(); step();
    end

    // 2: diff=7 adds one point per cycle, then saturation of pend
    diff = 3'd7;
    pulse();
    chk_eq("t2_lat", 32'(score_bcd), 32'h3);
    for (int k = 0; k < 8; k++) begin
      step();
      chk_eq("t2_step", 32'(score_bcd), 32'(exp_steps[k]));
    end
    chk_eq("t2_busy", 32'(busy), 32'h0);
    pass_evt = 1'b1;
    repeat (6) step();
    pass_evt = 1'b0;
    repeat (30) step();
    chk_eq("t2_sat_busy", 32'(busy), 32'h1);
    step();
    chk_eq("t2_sat_busy_lo", 32'(busy), 32'h0);
    chk_eq("t2_sat_score", 32'(score_bcd), 32'h0047);
    // pause blocks accepts
    pause = 1'b1;
    pulse();
    step();
    chk_eq("t2_pause", 32'(score_bcd), 32'h0047);
    pause = 1'b0;

    // 3: BCD carries and the 9999 ceiling
    reset = 1'b1; step(); reset = 1'b0;
    diff = 3'd0;
    hold(9);
    chk_eq("t3_9", 32'(score_bcd), 32'h0009);
    pulse(); step();
    chk_eq("t3_10", 32'(score_bcd), 32'h0010);
    chk_eq("t3_disp_lag", 32'(disp_bcd), 32'h0009);
    hold(989);
    chk_eq("t3_999", 32'(score_bcd), 32'h0999);
    pulse(); step();
    chk_eq("t3_1000", 32'(score_bcd), 32'h1000);
    hold(8999);
    chk_eq("t3_9999", 32'(score_bcd), 32'h9999);
    diff = 3'd4;
    pulse();
    repeat (4) step();
    chk_eq("t3_sat_busy", 32'(busy), 32'h1);
    chk_eq("t3_sat_mid", 32'(score_bcd), 32'h9999);
    step();
    chk_eq("t3_drain_busy", 32'(busy), 32'h0);
    chk_eq("t3_sat_end", 32'(score_bcd), 32'h9999);

    // 4: fail right after a pass, drain completes, commit new high
    reset = 1'b1; step(); reset = 1'b0;
    diff = 3'd4;
    pulse();
    failed = 1'b1;
    step();
    pass_evt = 1'b1;
    step();
    pass_evt = 1'b0;
    repeat (3) step();
    chk_eq("t4_score", 32'(score_bcd), 32'h0005);
    chk_eq("t4_busy", 32'(busy), 32'h0);
    chk_eq("t4_disp", 32'(disp_bcd), 32'h0004);
    step();
    chk_eq("t4_high_pre", 32'(high_bcd), 32'h0000);
    step();
    chk_eq("t4_high", 32'(high_bcd), 32'h0005);
    chk_eq("t4_nh", 32'(new_high), 32'h1);
    failed = 1'b0;
    step();
    chk_eq("t4_exit_score", 32'(score_bcd), 32'h0000);
    chk_eq("t4_exit_high", 32'(high_bcd), 32'h0005);
    chk_eq("t4_exit_nh", 32'(new_high), 32'h1);

    // 5: lower second game, OVER alternates score/high
    diff = 3'd1;
    pulse();
    chk_eq("t5_nh_clr", 32'(new_high), 32'h0);
    step(); step();
    chk_eq("t5_score", 32'(score_bcd), 32'h0002);
    failed = 1'b1;
    step(); step(); step();
    chk_eq("t5_high", 32'(high_bcd), 32'h0005);
    chk_eq("t5_nh", 32'(new_high), 32'h0);
    for (int k = 0; k < 12; k++) begin
      step();
      chk_eq("t5_disp", 32'(disp_bcd), 32'(exp_disp[k]));
    end
    failed = 1'b0;
    step();
    chk_eq("t5_exit_score", 32'(score_bcd), 32'h0000);
    chk_eq("t5_exit_high", 32'(high_bcd), 32'h0005);

    // 6: equal score keeps high, then reset mid-drain
    diff = 3'd4;
    pulse();
    repeat (5) step();
    chk_eq("t6_score", 32'(score_bcd), 32'h0005);
    failed = 1'b1;
    step(); step(); step();
    chk_eq("t6_high", 32'(high_bcd), 32'h0005);
    chk_eq("t6_nh", 32'(new_high), 32'h0);
    failed = 1'b0;
    step();
    diff = 3'd6;
    pulse();
    failed = 1'b1;
    step();
    chk_eq("t6_pre_busy", 32'(busy), 32'h1);
    chk_eq("t6_pre_score", 32'(score_bcd), 32'h0001);
    reset = 1'b1;
    step();
    chk_eq("t6_rst_score", 32'(score_bcd), 32'h0);
    chk_eq("t6_rst_high",  32'(high_bcd),  32'h0);
    chk_eq("t6_rst_disp",  32'(disp_bcd),  32'h0);
    chk_eq("t6_rst_nh",    32'(new_high),  32'h0);
    chk_eq("t6_rst_busy",  32'(busy),      32'h0);
    reset = 1'b0;
    failed = 1'b0;
    repeat (3) step();
    chk_eq("t6_post_score", 32'(score_bcd), 32'h0);
    chk_eq("t6_post_busy",  32'(busy),      32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
